spi_command_controller: RTL and testbench



---
 rtl/spi_command_controller.sv | 169 ++++++++++++++++
 tb/tb_spi_command_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_command_controller.sv
// SPI slave command front end: oversamples a mode-0 SPI host in the system clock domain
// and turns header+word frames into single-cycle write/read strobes for the memory managers.
module spi_command_controller #(
  parameter int MESSAGE_BIT_WIDTH       = 32,
  parameter int START_ADDRESS_BIT_WIDTH = 14,
  parameter int CODE_BIT_WIDTH          = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               spi_sck,
  input  logic                               spi_cs_n,
  input  logic                               spi_mosi,
  output logic                               spi_miso,
  output logic                               program_memory_new,
  output logic                               read_memory_sync,
  output logic [CODE_BIT_WIDTH-1:0]          memory_code,
  output logic [START_ADDRESS_BIT_WIDTH-1:0] spi_address,
  output logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_in,
  input  logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_out,
  output logic                               busy
);

  localparam int HeaderBits = 2 + CODE_BIT_WIDTH + START_ADDRESS_BIT_WIDTH;
  localparam int MaxBits    = (MESSAGE_BIT_WIDTH > HeaderBits) ? MESSAGE_BIT_WIDTH : HeaderBits;
  localparam int CntW       = $clog2(MaxBits + 1);
  localparam int AW         = START_ADDRESS_BIT_WIDTH;
  localparam int MW         = MESSAGE_BIT_WIDTH;

  localparam logic [CntW-1:0] HdrLast  = CntW'(HeaderBits - 1);
  localparam logic [CntW-1:0] WordLast = CntW'(MW - 1);
  localparam logic [CntW-1:0] WordFull = CntW'(MW);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [AW-1:0]   AddrOne  = AW'(1);

  typedef enum logic [2:0] {
    IDLE, HEADER, WRITE_DATA, READ_FETCH, READ_CAPTURE, READ_SHIFT, DISCARD
  } state_t;

  state_t state;

  logic sck_s1, sck_s2, sck_h;
  logic cs_s1, cs_s2, cs_h;
  logic mosi_s1, mosi_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_h   <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_h    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= spi_sck;
      sck_s2  <= sck_s1;
      sck_h   <= sck_s2;
      cs_s1   <= spi_cs_n;
      cs_s2   <= cs_s1;
      cs_h    <= cs_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  logic sck_rise, sck_fall, cs_fall;
  assign sck_rise = sck_s2 & ~sck_h;
  assign sck_fall = ~sck_s2 & sck_h;
  assign cs_fall  = ~cs_s2 & cs_h;

  logic [MaxBits-2:0] rx_shift;
  logic [MaxBits-1:0] rx_next;
  logic [1:0]         hdr_op;
  logic [CntW-1:0]    bit_cnt;
  logic [MW-1:0]      tx_shift;

  // rx_next already contains the bit being sampled on this rise event.
  assign rx_next = {rx_shift, mosi_s2};
  assign hdr_op  = rx_next[HeaderBits-1 -: 2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      rx_shift           <= '0;
      bit_cnt            <= '0;
      tx_shift           <= '0;
      spi_miso           <= 1'b0;
      program_memory_new <= 1'b0;
      read_memory_sync   <= 1'b0;
      memory_code        <= '0;
      spi_address        <= '0;
      spi_data_in        <= '0;
      busy               <= 1'b0;
    end else begin
      program_memory_new <= 1'b0;
      read_memory_sync   <= 1'b0;
      busy               <= ~cs_s2;
      // The write strobe has seen its own address; advance for the next word.
      if (program_memory_new) spi_address <= spi_address + AddrOne;

      if (cs_s2 && state != IDLE) begin
        state    <= IDLE;
        spi_miso <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            state    <= HEADER;
            bit_cnt  <= '0;
            rx_shift <= '0;
          end
          HEADER: if (sck_rise) begin
            rx_shift <= rx_next[MaxBits-2:0];
            if (bit_cnt == HdrLast) begin
              bit_cnt     <= '0;
              memory_code <= rx_next[AW +: CODE_BIT_WIDTH];
              spi_address <= rx_next[AW-1:0];
              case (hdr_op)
                2'b01: state <= WRITE_DATA;
                2'b10: begin
                  state            <= READ_FETCH;
                  read_memory_sync <= 1'b1;
                end
                default: state <= DISCARD;
              endcase
            end else begin
              bit_cnt <= bit_cnt + CntOne;
            end
          end
          WRITE_DATA: if (sck_rise) begin
            rx_shift <= rx_next[MaxBits-2:0];
            if (bit_cnt == WordLast) begin
              bit_cnt            <= '0;
              spi_data_in        <= rx_next[MW-1:0];
              program_memory_new <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CntOne;
            end
          end
          // Strobe cycle; the manager registers the read, data is valid one cycle later.
          READ_FETCH: state <= READ_CAPTURE;
          READ_CAPTURE: begin
            spi_miso    <= spi_data_out[MW-1];
            tx_shift    <= {spi_data_out[MW-2:0], 1'b0};
            spi_address <= spi_address + AddrOne;
            bit_cnt     <= '0;
            state       <= READ_SHIFT;
          end
          READ_SHIFT: begin
            if (sck_rise && bit_cnt != WordFull) bit_cnt <= bit_cnt + CntOne;
            // The fall before the first rise of a word must not disturb the preloaded MSB.
            if (sck_fall) begin
              if (bit_cnt == WordFull) begin
                state            <= READ_FETCH;
                read_memory_sync <= 1'b1;
              end else if (bit_cnt != '0) begin
                spi_miso <= tx_shift[MW-1];
                tx_shift <= {tx_shift[MW-2:0], 1'b0};
              end
            end
          end
          DISCARD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_command_controller.sv
// Directed bench for spi_command_controller: a bit-banged SPI host, a synchronous memory
// model, and strobe/MISO scoreboards fed from expected queues.
`timescale 1ns/100ps
module tb_spi_command_controller;

  localparam int MW = 32;
  localparam int SW = 14;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spi_sck = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          spi_miso;
  logic          program_memory_new;
  logic          read_memory_sync;
  logic [CW-1:0] memory_code;
  logic [SW-1:0] spi_address;
  logic [MW-1:0] spi_data_in;
  logic [MW-1:0] spi_data_out = '0;
  logic          busy;

  spi_command_controller dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .spi_sck            (spi_sck),
    .spi_cs_n           (spi_cs_n),
    .spi_mosi           (spi_mosi),
    .spi_miso           (spi_miso),
    .program_memory_new (program_memory_new),
    .read_memory_sync   (read_memory_sync),
    .memory_code        (memory_code),
    .spi_address        (spi_address),
    .spi_data_in        (spi_data_in),
    .spi_data_out       (spi_data_out),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // Manager model: synchronous read returning address + 0xA5000000.
  always @(posedge clk)
    if (read_memory_sync) spi_data_out <= 32'hA500_0000 + {{(MW-SW){1'b0}}, spi_address};

  int vectors = 0;
  int miscompares = 0;
  bit min_mode = 1'b0;
  logic [CW-1:0] exp_code;
  logic [SW-1:0] exp_addr;

  logic [CW+SW+MW-1:0] wr_exp_q[$];
  logic [CW+SW-1:0]    rd_exp_q[$];
  logic [MW-1:0]       miso_exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe pops its expected entry; strobe shape checked each cycle.
  logic prev_wr = 1'b0, prev_rd = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (program_memory_new) begin
        if (wr_exp_q.size() == 0) check("unexpected_write", {memory_code, spi_address, spi_data_in}, '1);
        else check("write_strobe", {memory_code, spi_address, spi_data_in}, wr_exp_q.pop_front());
      end
      if (read_memory_sync) begin
        if (rd_exp_q.size() == 0) check("unexpected_read", {memory_code, spi_address}, '1);
        else check("read_strobe", {memory_code, spi_address}, rd_exp_q.pop_front());
      end
      if (program_memory_new && read_memory_sync) begin
        miscompares++;
        $display("FAIL strobe_exclusive: both strobes high at %0t", $time);
      end
      if ((program_memory_new && prev_wr) || (read_memory_sync && prev_rd)) begin
        miscompares++;
        $display("FAIL strobe_width: strobe wider than one cycle at %0t", $time);
      end
    end
    prev_wr = program_memory_new;
    prev_rd = read_memory_sync;
  end

  task automatic half_wait();
    if (min_mode) #80;
    else #(85 + $urandom_range(0, 15));
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    spi_mosi = b;
    half_wait();
    r = spi_miso;
    spi_sck = 1'b1;
    half_wait();
    spi_sck = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    logic r;
    for (int i = n - 1; i >= 0; i--) bit_xfer(v[i], r);
  endtask

  task automatic open_frame(input logic [1:0] op, input logic [CW-1:0] code, input logic [SW-1:0] addr);
    exp_code = code;
    exp_addr = addr;
    spi_cs_n = 1'b0;
    half_wait();
    send_bits({44'd0, op, code, addr}, 20);
  endtask

  task automatic close_frame();
    half_wait();
    spi_cs_n = 1'b1;
    #120;
  endtask

  task automatic write_word(input logic [MW-1:0] w);
    wr_exp_q.push_back({exp_code, exp_addr, w});
    exp_addr = exp_addr + 14'd1;
    send_bits({32'd0, w}, 32);
  endtask

  task automatic read_frame(input logic [CW-1:0] code, input logic [SW-1:0] addr, input int n);
    logic [SW-1:0] a;
    logic [MW-1:0] got;
    logic r;
    a = addr;
    for (int k = 0; k <= n; k++) begin
      rd_exp_q.push_back({code, a});
      if (k < n) miso_exp_q.push_back(32'hA500_0000 + {18'd0, a});
      a = a + 14'd1;
    end
    open_frame(2'b10, code, addr);
    for (int k = 0; k < n; k++) begin
      for (int i = MW - 1; i >= 0; i--) begin
        bit_xfer(1'b0, r);
        got[i] = r;
      end
      if (miso_exp_q.size() == 0) check("miso_word_unexpected", got, '1);
      else check("miso_word", got, miso_exp_q.pop_front());
    end
    close_frame();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_miso"}, spi_miso, 0);
    check({tag, "_wr"}, program_memory_new, 0);
    check({tag, "_rd"}, read_memory_sync, 0);
    check({tag, "_code"}, memory_code, 0);
    check({tag, "_addr"}, spi_address, 0);
    check({tag, "_data"}, spi_data_in, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    // Fractional offset keeps host edges off the DUT clock edges.
    #20.3;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    #100;

    // Single write
    open_frame(2'b01, 4'd3, 14'h0010);
    write_word(32'hDEAD_BEEF);
    close_frame();
    check("write_busy_after", busy, 0);

    // Burst write across the address wrap
    open_frame(2'b01, 4'd6, 14'h3FFF);
    write_word(32'h1111_0001);
    write_word(32'h2222_0002);
    write_word(32'hF0F0_5A5A);
    close_frame();

    // Burst read with prefetch
    read_frame(4'd2, 14'h0005, 2);
    check("read_miso_after_close", spi_miso, 0);

    // Abort after 17 data bits
    open_frame(2'b01, 4'd5, 14'h0100);
    send_bits(64'h1_2345, 17);
    check("abort_busy_open", busy, 1);
    close_frame();
    check("abort_busy", busy, 0);
    check("abort_addr_kept", spi_address, 14'h0100);
    check("abort_code_kept", memory_code, 4'd5);

    // Illegal opcode frame
    open_frame(2'b11, 4'd7, 14'h0222);
    send_bits(64'hCAFE_F00D, 32);
    check("illegal_busy_open", busy, 1);
    send_bits(64'h1234_5678, 32);
    close_frame();
    check("illegal_busy", busy, 0);

    // Reset in the middle of a write word
    open_frame(2'b01, 4'd9, 14'h0042);
    send_bits(64'h3FF, 10);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #50;
    rst_n = 1'b1;
    #100;
    open_frame(2'b01, 4'd2, 14'h00AB);
    write_word(32'h1234_5678);
    close_frame();

    // Minimum SCK period with random phase
    min_mode = 1'b1;
    #($urandom_range(0, 9));
    read_frame(4'hC, 14'h3FFE, 3);
    #($urandom_range(0, 9));
    open_frame(2'b01, 4'd1, 14'h0777);
    write_word($urandom());
    write_word($urandom());
    close_frame();

    for (int i = 0; i < 200 && (wr_exp_q.size() != 0 || rd_exp_q.size() != 0); i++) #10;
    check("write_queue_drained", wr_exp_q.size(), 0);
    check("read_queue_drained", rd_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
